// File: rtl/serial_frame_loader.sv
// Parallel-to-serial frame feeder: captures a WIDTH-bit word on start and
// streams it MSB-first on s_dat against a divided shift clock s_clk.
module serial_frame_loader #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] p_data,
  output logic             busy,
  output logic             done,
  output logic             s_clk,
  output logic             s_dat
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    bitcnt;
  logic [DW-1:0]    divcnt;

  assign shreg_nxt = shreg << 1;

  // s_dat only moves on the HIGH->LOW boundary (or frame entry/exit), so it
  // is always settled well before the next s_clk rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      s_clk  <= 1'b0;
      s_dat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg  <= p_data;
            s_dat  <= p_data[WIDTH-1];
            bitcnt <= '0;
            divcnt <= '0;
            busy   <= 1'b1;
            state  <= LOW;
          end
        end
        LOW: begin
          if (divcnt == LAST_DIV) begin
            s_clk  <= 1'b1;
            divcnt <= '0;
            state  <= HIGH;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        HIGH: begin
          if (divcnt == LAST_DIV) begin
            s_clk  <= 1'b0;
            divcnt <= '0;
            if (bitcnt == LAST_BIT) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              s_dat <= 1'b0;
              state <= DONE;
            end else begin
              shreg  <= shreg_nxt;
              s_dat  <= shreg_nxt[WIDTH-1];
              bitcnt <= bitcnt + 1'b1;
              state  <= LOW;
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
